// File: rtl/acq_coh_acc_if.sv
// Sample-in / sum-out handshake bundle for the coherent accumulator.
// slave is the accumulator side; master is the producer/consumer side.
interface acq_coh_acc_if #(
    parameter int IN_WIDTH   = 4,
    parameter int DATA_WIDTH = 9
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [IN_WIDTH-1:0]   in_i;
    logic signed [IN_WIDTH-1:0]   in_q;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_i;
    logic signed [DATA_WIDTH-1:0] out_q;

    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  in_ready, out_valid, out_i, out_q
    );

    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output in_ready, out_valid, out_i, out_q
    );
endinterface

// File: rtl/acq_coh_acc.sv
// Coherent I/Q accumulator: sums acc_len samples per block; COH_ACC_SAT_EN selects saturate vs wrap.
// Latency: last sample of a block accepted in cycle N -> out_valid in N+1.
// Backpressure: one finished sum may park behind the output register (PEND); in_ready drops until it drains.
module acq_coh_acc #(
    parameter int IN_WIDTH   = 4,
    parameter int DATA_WIDTH = 9,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] acc_len,
    acq_coh_acc_if.slave         bus,
    output logic                 overflow
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ACC = 1'b0, PEND = 1'b1} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] acc_i, acc_q, sum_i, sum_q, out_i_r, out_q_r;
    logic [CNT_WIDTH-1:0]  cnt, len_lat, len_cur;
    logic                  out_valid_r, in_ready_c;
    logic                  take, last, out_xfer, slot_free;

    // The first sample of a block uses the live acc_len; the rest use the latched copy.
    assign len_cur   = (cnt == '0) ? ((acc_len == '0) ? CNT_ONE : acc_len) : len_lat;
    assign take      = bus.in_valid & in_ready_c;
    assign last      = take & (cnt == len_cur - CNT_ONE);
    assign out_xfer  = out_valid_r & bus.out_ready;
    assign slot_free = ~out_valid_r | out_xfer;

`ifdef COH_ACC_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH:0] raw_i, raw_q;
    logic                ovf_i, ovf_q, ovf_r;

    assign raw_i = {acc_i[DATA_WIDTH-1], acc_i}
                 + {{(DATA_WIDTH+1-IN_WIDTH){bus.in_i[IN_WIDTH-1]}}, bus.in_i};
    assign raw_q = {acc_q[DATA_WIDTH-1], acc_q}
                 + {{(DATA_WIDTH+1-IN_WIDTH){bus.in_q[IN_WIDTH-1]}}, bus.in_q};
    assign ovf_i = raw_i[DATA_WIDTH] ^ raw_i[DATA_WIDTH-1];
    assign ovf_q = raw_q[DATA_WIDTH] ^ raw_q[DATA_WIDTH-1];
    assign sum_i = ovf_i ? (raw_i[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : raw_i[DATA_WIDTH-1:0];
    assign sum_q = ovf_q ? (raw_q[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : raw_q[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (clear) begin
            ovf_r <= 1'b0;
        end else if (take && (ovf_i || ovf_q)) begin
            ovf_r <= 1'b1;
        end
    end

    assign overflow = ovf_r;
`else
    assign sum_i    = acc_i + {{(DATA_WIDTH-IN_WIDTH){bus.in_i[IN_WIDTH-1]}}, bus.in_i};
    assign sum_q    = acc_q + {{(DATA_WIDTH-IN_WIDTH){bus.in_q[IN_WIDTH-1]}}, bus.in_q};
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:     if (last && !slot_free) state_nxt = PEND;
                PEND:    if (out_xfer)           state_nxt = ACC;
                default:                         state_nxt = ACC;
            endcase
        end
    end

    always_comb begin
        in_ready_c = 1'b0;
        if (!rst && state == ACC) begin
            in_ready_c = enable;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            len_lat     <= '0;
            out_valid_r <= 1'b0;
            out_i_r     <= '0;
            out_q_r     <= '0;
        end else if (clear) begin
            acc_i       <= '0;
            acc_q       <= '0;
            cnt         <= '0;
            out_valid_r <= 1'b0;
        end else if (state == PEND) begin
            // The parked sum moves up as the consumer takes the current one.
            if (out_xfer) begin
                out_i_r <= acc_i;
                out_q_r <= acc_q;
                acc_i   <= '0;
                acc_q   <= '0;
                cnt     <= '0;
            end
        end else begin
            if (out_xfer) begin
                out_valid_r <= 1'b0;
            end
            if (take) begin
                if (cnt == '0) begin
                    len_lat <= len_cur;
                end
                if (last && slot_free) begin
                    out_i_r     <= sum_i;
                    out_q_r     <= sum_q;
                    out_valid_r <= 1'b1;
                    acc_i       <= '0;
                    acc_q       <= '0;
                    cnt         <= '0;
                end else if (last) begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_i     = out_i_r;
    assign bus.out_q     = out_q_r;
endmodule

// File: tb/tb_acq_coh_acc.sv
// Bench for acq_coh_acc: queue-based reference model checked every cycle plus directed literal checks.
module tb_acq_coh_acc;
    localparam int IN_W = 4;
    localparam int DW   = 9;
    localparam int MAXV = (1 << (DW-1)) - 1;
    localparam int MINV = -(1 << (DW-1));
`ifdef COH_ACC_SAT_EN
    localparam int T4_I   = -256;
    localparam int T4_OVF = 1;
`else
    localparam int T4_I   = 8;
    localparam int T4_OVF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable, clear, overflow;
    logic [5:0] acc_len;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    acq_coh_acc_if #(.IN_WIDTH(IN_W), .DATA_WIDTH(DW)) bus ();

    acq_coh_acc #(.IN_WIDTH(IN_W), .DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (clear),
        .acc_len  (acc_len),
        .bus      (bus),
        .overflow (overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: finished sums wait in a two-deep queue (output register plus one parked sum).
    int q_i[$];
    int q_q[$];
    int blk_n, blk_len, sum_i, sum_q;
    bit m_ovf;

    function automatic int clampv(input int v);
        return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    endfunction

    function automatic int wrapv(input int v);
        int m;
        m = v & ((1 << DW) - 1);
        return (m > MAXV) ? m - (1 << DW) : m;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int  sz, t;
        bit  take;
        if (rst || clear) begin
            q_i.delete();
            q_q.delete();
            blk_n = 0;
            sum_i = 0;
            sum_q = 0;
            m_ovf = 1'b0;
        end else begin
            sz   = q_i.size();
            take = bus.in_valid && enable && (sz < 2);
            if (sz > 0 && bus.out_ready) begin
                void'(q_i.pop_front());
                void'(q_q.pop_front());
            end
            if (take) begin
                if (blk_n == 0) blk_len = (acc_len == 0) ? 1 : int'(acc_len);
`ifdef COH_ACC_SAT_EN
                t = sum_i + int'(bus.in_i);
                if (clampv(t) != t) m_ovf = 1'b1;
                sum_i = clampv(t);
                t = sum_q + int'(bus.in_q);
                if (clampv(t) != t) m_ovf = 1'b1;
                sum_q = clampv(t);
`else
                sum_i = sum_i + int'(bus.in_i);
                sum_q = sum_q + int'(bus.in_q);
`endif
                blk_n++;
                if (blk_n == blk_len) begin
                    q_i.push_back(wrapv(sum_i));
                    q_q.push_back(wrapv(sum_q));
                    blk_n = 0;
                    sum_i = 0;
                    sum_q = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready",  bus.in_ready,  int'(!rst && enable && q_i.size() < 2));
        check("out_valid", bus.out_valid, int'(q_i.size() > 0));
        check("overflow",  overflow,      int'(m_ovf));
        if (q_i.size() > 0) begin
            check("out_i", bus.out_i, q_i[0]);
            check("out_q", bus.out_q, q_q[0]);
        end
    end

    task automatic drive(input bit v, input int i, input int q, input bit ordy);
        bus.in_valid  = v;
        bus.in_i      = IN_W'(i);
        bus.in_q      = IN_W'(q);
        bus.out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        enable = 1'b0; clear = 1'b0; acc_len = '0;
        bus.in_valid = 1'b0; bus.in_i = '0; bus.in_q = '0; bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_i",     bus.out_i,     0);
        check("rst_out_q",     bus.out_q,     0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_overflow",  overflow,      0);
        @(posedge clk); #2;
        rst = 1'b0;
        enable = 1'b1;

        // Four-sample block with a free consumer.
        acc_len = 6'd4;
        for (int k = 1; k <= 4; k++) drive(1'b1, k, -k, 1'b1);
        check("t1_valid", bus.out_valid, 1);
        check("t1_i",     bus.out_i,     10);
        check("t1_q",     bus.out_q,     -10);
        drive(1'b0, 0, 0, 1'b1);
        check("t1_drain", bus.out_valid, 0);

        // Stalled consumer: second sum parks and input stalls.
        acc_len = 6'd2;
        for (int k = 0; k < 2; k++) drive(1'b1, 3, 0, 1'b0);
        check("t2_first_i", bus.out_i, 6);
        for (int k = 0; k < 2; k++) drive(1'b1, 3, 0, 1'b0);
        check("t2_pend_rdy", bus.in_ready,  0);
        check("t2_pend_i",   bus.out_i,     6);
        drive(1'b0, 0, 0, 1'b1);
        check("t2_move_vld", bus.out_valid, 1);
        check("t2_move_i",   bus.out_i,     6);
        check("t2_move_rdy", bus.in_ready,  1);
        drive(1'b0, 0, 0, 1'b1);
        check("t2_empty", bus.out_valid, 0);

        // acc_len of zero behaves as one: pass-through.
        acc_len = 6'd0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, -8, 7, 1'b1);
            check("t3_valid", bus.out_valid, 1);
            check("t3_i",     bus.out_i,     -8);
            check("t3_q",     bus.out_q,     7);
        end
        drive(1'b0, 0, 0, 1'b1);

        // Longest block of most-negative samples.
        acc_len = 6'd63;
        for (int k = 0; k < 63; k++) drive(1'b1, -8, 0, 1'b1);
        check("t4_valid", bus.out_valid, 1);
        check("t4_i",     bus.out_i,     T4_I);
        check("t4_q",     bus.out_q,     0);
        check("t4_ovf",   overflow,      T4_OVF);
        drive(1'b0, 0, 0, 1'b1);
        check("t4_ovf_sticky", overflow, T4_OVF);

        // Clear mid-block, acc_len change mid-block, enable gap.
        acc_len = 6'd8;
        for (int k = 0; k < 5; k++) drive(1'b1, 1, 2, 1'b1);
        clear = 1'b1;
        drive(1'b1, 1, 2, 1'b1);
        clear = 1'b0;
        check("t5_clr_ovf",   overflow,      0);
        check("t5_clr_valid", bus.out_valid, 0);
        for (int k = 0; k < 2; k++) drive(1'b1, 1, 2, 1'b1);
        acc_len = 6'd3;
        for (int k = 0; k < 2; k++) drive(1'b1, 1, 2, 1'b1);
        enable = 1'b0;
        for (int k = 0; k < 2; k++) drive(1'b1, 5, 5, 1'b1);
        check("t5_dis_rdy", bus.in_ready, 0);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) drive(1'b1, 1, 2, 1'b1);
        check("t5_valid", bus.out_valid, 1);
        check("t5_i",     bus.out_i,     8);
        check("t5_q",     bus.out_q,     16);
        check("t5_ovf",   overflow,      0);
        drive(1'b0, 0, 0, 1'b1);

        // Reset mid-block with a sum waiting.
        acc_len = 6'd2;
        for (int k = 0; k < 3; k++) drive(1'b1, 1, 1, 1'b0);
        check("t6_pre_vld", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_vld", bus.out_valid, 0);
        check("t6_rst_i",   bus.out_i,     0);
        check("t6_rst_q",   bus.out_q,     0);
        check("t6_rst_rdy", bus.in_ready,  0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) drive(1'b1, 2, 3, 1'b1);
        check("t6_post_vld", bus.out_valid, 1);
        check("t6_post_i",   bus.out_i,     4);
        check("t6_post_q",   bus.out_q,     6);
        drive(1'b0, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
